// File: rtl/fwrisc_alu_seq.sv
// fwrisc_alu_seq: multi-cycle issue/operand-fetch/writeback sequencer driving the ALU
module fwrisc_alu_seq #(
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_op,
  input  logic [4:0]        instr_rs1,
  input  logic [4:0]        instr_rs2,
  input  logic [4:0]        instr_rd,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wen,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, RA, RB, EX, WB} state_t;
  state_t state, state_nxt;
  logic [4:0] op_q, rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] imm_q, op_a_q, op_b_q;
  logic use_imm_q, in_wb, illegal;
  // state register, latched instruction fields and captured operands
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        op_q      <= instr_op;
        rs1_q     <= instr_rs1;
        rs2_q     <= instr_rs2;
        rd_q      <= instr_rd;
        imm_q     <= instr_imm;
        use_imm_q <= instr_use_imm;
      end
      if (state == RB) op_a_q <= (ZERO_REG && rs1_q == 5'd0) ? '0 : rf_rdata;
      if (state == EX) op_b_q <= use_imm_q ? imm_q : (ZERO_REG && rs2_q == 5'd0) ? '0 : rf_rdata;
    end
  end
  // next state and outputs; everything forced to 0 while reset is high
  always_comb begin
    state_nxt   = state == IDLE ? (instr_valid ? RA : IDLE) :
                  state == RA   ? RB :
                  state == RB   ? EX :
                  state == EX   ? WB : IDLE;
    in_wb       = !reset && state == WB;
    illegal     = op_q > 5'd4;
    instr_ready = !reset && state == IDLE;
    rf_raddr    = reset ? 5'd0 : state == RA ? rs1_q : state == RB ? rs2_q : 5'd0;
    rf_wen      = in_wb && !illegal && !(ZERO_REG && rd_q == 5'd0);
    rf_waddr    = rf_wen ? rd_q : 5'd0;
    rf_wdata    = rf_wen ? alu_out : '0;
    alu_op_a    = reset ? '0 : op_a_q;
    alu_op_b    = reset ? '0 : op_b_q;
    alu_op      = (!reset && state != IDLE) ? op_q : 5'd0;
    done        = in_wb;
    err         = in_wb && illegal;
  end
endmodule
